// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU instruction and data memory ports onto one shared
// physical-memory port, with a bounded-starvation guarantee for instruction fetch.
module cpu_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_mem_read,
    input  logic [31:0] inst_mem_address,
    output logic [31:0] inst_mem_rdata,
    output logic        inst_mem_resp,

    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  data_mem_byte_enable,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic data_req;
    logic grant_d;
    logic grant_i;
    logic unused_addr_bits;

    // Data wins unless an instruction fetch has already waited STARVE_LIMIT grants.
    assign data_req = data_mem_read | data_mem_write;
    assign grant_d  = data_req && (!inst_mem_read || (starve_cnt < LIMIT));
    assign grant_i  = !grant_d && inst_mem_read;

    // Byte offsets are dropped: the shared port is word addressed.
    assign unused_addr_bits = ^{inst_mem_address[1:0], data_mem_address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            inst_mem_rdata   <= '0;
            inst_mem_resp    <= 1'b0;
            data_mem_rdata   <= '0;
            data_mem_resp    <= 1'b0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= '0;
        end else begin
            inst_mem_resp <= 1'b0;
            data_mem_resp <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state            <= SERVE_D;
                        pmem_address     <= {data_mem_address[AW-1:2], 2'b00};
                        pmem_wdata       <= data_mem_wdata;
                        // A simultaneous read and write is serviced as a write.
                        pmem_write       <= data_mem_write;
                        pmem_read        <= !data_mem_write;
                        pmem_byte_enable <= data_mem_write ? data_mem_byte_enable
                                                           : {BW{1'b1}};
                        if (!inst_mem_read) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < LIMIT) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else if (grant_i) begin
                        state            <= SERVE_I;
                        pmem_address     <= {inst_mem_address[AW-1:2], 2'b00};
                        pmem_wdata       <= '0;
                        pmem_write       <= 1'b0;
                        pmem_read        <= 1'b1;
                        pmem_byte_enable <= {BW{1'b1}};
                        starve_cnt       <= '0;
                    end
                end

                SERVE_I: begin
                    if (pmem_resp) begin
                        state          <= DONE;
                        pmem_read      <= 1'b0;
                        pmem_write     <= 1'b0;
                        inst_mem_rdata <= pmem_rdata;
                        inst_mem_resp  <= 1'b1;
                    end
                end

                SERVE_D: begin
                    if (pmem_resp) begin
                        state          <= DONE;
                        pmem_read      <= 1'b0;
                        pmem_write     <= 1'b0;
                        data_mem_rdata <= pmem_write ? DW'(0) : pmem_rdata;
                        data_mem_resp  <= 1'b1;
                    end
                end

                // One dead cycle so a request still held during its resp is not re-served.
                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: random CPU traffic, a behavioural
// memory responder, and a reference model of memory contents and grant order.
module tb_cpu_mem_arbiter;

    localparam int unsigned STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_resp;
    logic        data_mem_read;
    logic        data_mem_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mem_byte_enable;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    cpu_mem_arbiter #(.STARVE_LIMIT(STARVE), .CNT_W(3)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_mem_read        (inst_mem_read),
        .inst_mem_address     (inst_mem_address),
        .inst_mem_rdata       (inst_mem_rdata),
        .inst_mem_resp        (inst_mem_resp),
        .data_mem_read        (data_mem_read),
        .data_mem_write       (data_mem_write),
        .data_mem_address     (data_mem_address),
        .data_mem_wdata       (data_mem_wdata),
        .data_mem_byte_enable (data_mem_byte_enable),
        .data_mem_rdata       (data_mem_rdata),
        .data_mem_resp        (data_mem_resp),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_address         (pmem_address),
        .pmem_wdata           (pmem_wdata),
        .pmem_byte_enable     (pmem_byte_enable),
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction region is 0x000-0x0FF, data region 0x100-0x1FF: address bit 8 tells the port.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h60) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic [31:0] pstore   [logic [31:0]];
    logic [31:0] ref_store[logic [31:0]];

    function automatic logic [31:0] pget(input logic [31:0] a);
        if (pstore.exists(a)) return pstore[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rget(input logic [31:0] a);
        if (ref_store.exists(a)) return ref_store[a];
        return init_word(a);
    endfunction

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic        grant_log[$];

    logic [31:0] cur_i_addr, cur_d_addr, cur_d_wdata;
    logic [3:0]  cur_d_be;
    logic        cur_d_wr;
    int          last_lat;

    always @(posedge clk) cyc++;

    task automatic do_inst(input logic [31:0] a);
        int n;
        int t0;
        iq.push_back(init_word({a[31:2], 2'b00}));
        cur_i_addr       = a;
        inst_mem_address = a;
        inst_mem_read    = 1'b1;
        t0 = cyc;
        n  = 0;
        do begin @(negedge clk); n++; end while (!inst_mem_resp && n < 300);
        if (!inst_mem_resp) chk("inst_resp_timeout", 32'(inst_mem_resp), 32'd1);
        last_lat = cyc - t0;
        @(posedge clk); #1;
        inst_mem_read = 1'b0;
    endtask

    task automatic do_data(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        int n;
        logic [31:0] aw;
        aw = {a[31:2], 2'b00};
        if (wr) begin
            ref_store[aw] = merge(rget(aw), wd, be);
            dq.push_back(32'd0);
        end else begin
            dq.push_back(rget(aw));
        end
        cur_d_addr = a; cur_d_wr = wr; cur_d_wdata = wd; cur_d_be = be;
        data_mem_address = a; data_mem_wdata = wd; data_mem_byte_enable = be;
        data_mem_read = rd; data_mem_write = wr;
        n = 0;
        do begin @(negedge clk); n++; end while (!data_mem_resp && n < 300);
        if (!data_mem_resp) chk("data_resp_timeout", 32'(data_mem_resp), 32'd1);
        @(posedge clk); #1;
        data_mem_read  = 1'b0;
        data_mem_write = 1'b0;
    endtask

    // Physical memory responder with random (or fixed) latency.
    int fixed_lat = -1;
    bit hold      = 1'b0;
    bit stray     = 1'b0;
    bit active    = 1'b0;
    int wait_n    = 0;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (stray) begin
                pmem_resp = 1'b1;
                stray     = 1'b0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                active    = 1'b0;
                chk("strobe_drop_after_resp", 32'(pmem_read | pmem_write), 32'd0);
            end else if (hold) begin
                active = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!active) begin
                    active = 1'b1;
                    wait_n = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (wait_n == 0) begin
                    chk("pmem_rw_exclusive", 32'(pmem_read && pmem_write), 32'd0);
                    if (pmem_address[8]) begin
                        chk("pmem_d_addr", pmem_address, {cur_d_addr[31:2], 2'b00});
                        chk("pmem_d_is_write", 32'(pmem_write), 32'(cur_d_wr));
                        if (pmem_write) begin
                            chk("pmem_wdata", pmem_wdata, cur_d_wdata);
                            chk("pmem_be_w", 32'(pmem_byte_enable), 32'(cur_d_be));
                            pstore[pmem_address] = merge(pget(pmem_address), pmem_wdata,
                                                         pmem_byte_enable);
                            pmem_rdata = $urandom;
                        end else begin
                            chk("pmem_be_dr", 32'(pmem_byte_enable), 32'hF);
                            pmem_rdata = pget(pmem_address);
                        end
                    end else begin
                        chk("pmem_i_addr", pmem_address, {cur_i_addr[31:2], 2'b00});
                        chk("pmem_i_is_read", 32'(pmem_read), 32'd1);
                        chk("pmem_be_i", 32'(pmem_byte_enable), 32'hF);
                        pmem_rdata = pget(pmem_address);
                    end
                    pmem_resp = 1'b1;
                end else begin
                    wait_n--;
                end
            end else if (active) begin
                chk("strobe_held_until_resp", 32'd0, 32'd1);
                active = 1'b0;
            end
        end
    end

    // Monitor: resp timing, scoreboard pops, and grant-order reference model.
    logic i_prev = 1'b0, d_prev = 1'b0, strobe_prev = 1'b0;
    logic fire_prev = 1'b0, fire_d_prev = 1'b0;
    int   streak = 0;

    initial begin
        logic strobe;
        logic exp_d;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            strobe = pmem_read | pmem_write;
            if (rst) begin
                streak    = 0;
                fire_prev = 1'b0;
            end else begin
                chk("inst_resp_timing", 32'(inst_mem_resp), 32'(fire_prev && !fire_d_prev));
                chk("data_resp_timing", 32'(data_mem_resp), 32'(fire_prev && fire_d_prev));
                if (inst_mem_resp) begin
                    if (iq.size() == 0) chk("inst_resp_unexpected", 32'd1, 32'd0);
                    else begin e = iq.pop_front(); chk("inst_rdata", inst_mem_rdata, e); end
                end
                if (data_mem_resp) begin
                    if (dq.size() == 0) chk("data_resp_unexpected", 32'd1, 32'd0);
                    else begin e = dq.pop_front(); chk("data_rdata", data_mem_rdata, e); end
                end
                if (strobe && !strobe_prev) begin
                    exp_d = d_prev && (!i_prev || streak < int'(STARVE));
                    chk("grant_had_request", 32'(i_prev | d_prev), 32'd1);
                    chk("grant_port", 32'(pmem_address[8]), 32'(exp_d));
                    if (exp_d && i_prev) streak = (streak < int'(STARVE)) ? streak + 1 : streak;
                    else streak = 0;
                    grant_log.push_back(pmem_address[8]);
                end
                fire_prev   = strobe && pmem_resp;
                fire_d_prev = pmem_address[8];
            end
            i_prev      = inst_mem_read;
            d_prev      = data_mem_read | data_mem_write;
            strobe_prev = strobe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        rst = 1'b1;
        inst_mem_read = 1'b0; inst_mem_address = '0;
        data_mem_read = 1'b0; data_mem_write = 1'b0; data_mem_address = '0;
        data_mem_wdata = '0; data_mem_byte_enable = '0;
        cur_i_addr = '0; cur_d_addr = '0; cur_d_wdata = '0; cur_d_be = '0; cur_d_wr = 1'b0;
        last_lat = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_resp", 32'(inst_mem_resp), 32'd0);
        chk("rst_data_resp", 32'(data_mem_resp), 32'd0);
        chk("rst_inst_rdata", inst_mem_rdata, 32'd0);
        chk("rst_data_rdata", data_mem_rdata, 32'd0);
        chk("rst_pmem_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        chk("rst_pmem_addr", pmem_address, 32'd0);
        chk("rst_pmem_wdata", pmem_wdata, 32'd0);
        chk("rst_pmem_be", 32'(pmem_byte_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Lone instruction read, pmem answering one cycle after the strobe.
        fixed_lat = 1;
        do_inst(32'h0000_0062);
        chk("inst_latency", 32'(last_lat), 32'd3);

        // Simultaneous requests: data first, then instruction.
        fixed_lat = 0;
        g0 = grant_log.size();
        fork
            do_inst(32'h0000_0084);
            do_data(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'h0);
        join
        chk("simul_order_n", 32'(grant_log.size() - g0), 32'd2);
        if (grant_log.size() >= g0 + 2) begin
            chk("simul_first_data", 32'(grant_log[g0]), 32'd1);
            chk("simul_second_inst", 32'(grant_log[g0 + 1]), 32'd0);
        end

        // Partial write, read back, and concurrent read+write treated as write.
        fixed_lat = -1;
        do_data(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
        do_data(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        do_data(1'b1, 1'b1, 32'h0000_0105, 32'hCAFE_F00D, 4'b1100);
        do_data(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);

        // Starvation: instruction held, data back-to-back.
        g0 = grant_log.size();
        fork
            do_inst(32'h0000_0010);
            begin
                for (int k = 0; k < 6; k++)
                    do_data(1'b1, 1'b0, 32'h0000_0180 + 32'(4 * k), 32'h0, 4'h0);
            end
        join
        if (grant_log.size() >= g0 + 5) begin
            for (int k = 0; k < 5; k++)
                chk("starve_order", 32'(grant_log[g0 + k]), (k < 4) ? 32'd1 : 32'd0);
        end else begin
            chk("starve_grant_count", 32'(grant_log.size() - g0), 32'd7);
        end

        // Reset while a data read is in flight, then a stray pmem_resp.
        hold = 1'b1;
        data_mem_address = 32'h0000_01C0; data_mem_read = 1'b1;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
            chk("rst_test_strobe_up", 32'(pmem_read), 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        data_mem_read = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        chk("midrst_addr", pmem_address, 32'd0);
        chk("midrst_be", 32'(pmem_byte_enable), 32'd0);
        chk("midrst_resps", 32'({inst_mem_resp, data_mem_resp}), 32'd0);
        chk("midrst_rdata", inst_mem_rdata | data_mem_rdata, 32'd0);
        stray = 1'b1;
        repeat (4) @(negedge clk);
        hold = 1'b0;
        @(posedge clk); #1;

        // Random traffic on both ports.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int gap = int'($urandom_range(0, 3));
                    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
                    do_inst(32'($urandom_range(0, 255)));
                end
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    int gap = int'($urandom_range(0, 2));
                    int kind = int'($urandom_range(0, 2));
                    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
                    do_data(kind != 1, kind != 0, 32'h100 + 32'($urandom_range(0, 255)),
                            $urandom, 4'($urandom_range(0, 15)));
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
